// File: rtl/vend_service_controller.sv
// vend_service_controller: vending sequencer for credit, select, motor and change.
// Optional motor watchdog: define VEND_MOTOR_TIMEOUT_EN.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   coin5, coin10     one-cycle coin pulses
//   cancel            one-cycle refund request
//   sel[N_SEL]        product buttons, level-sampled
//   motor_req/sel     dispense request and one-hot lane
//   motor_done        one-cycle dispense-complete pulse
//   hopper_req/ack    eject one 5-unit coin handshake
//   credit            current credit
//   busy              state != IDLE
//   coin_reject       one-cycle pulse per refused coin
//   fault             sticky watchdog fault (0 without the feature)
module vend_service_controller #(
  parameter int N_SEL      = 4,
  parameter int PRICE      = 15,
  parameter int MAX_CREDIT = 40,
  parameter int CREDIT_W   = 6,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin5,
  input  logic                coin10,
  input  logic                cancel,
  input  logic [N_SEL-1:0]    sel,
  output logic                motor_req,
  output logic [N_SEL-1:0]    motor_sel,
  input  logic                motor_done,
  output logic                hopper_req,
  input  logic                hopper_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                coin_reject,
  output logic                fault
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  localparam logic [CREDIT_W-1:0] C5 =
    CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] C10 =
    CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] CPRICE =
    CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] CMAX =
    CREDIT_W'(MAX_CREDIT);

  state_t              state, state_n;
  logic [CREDIT_W-1:0] credit_n;
  logic                mreq_n;
  logic [N_SEL-1:0]    msel_n;
  logic                hreq_n;
  logic                rej_n;
  logic                busy_n;
  logic                has_coin;
  logic                sel_ok;
  logic                take_cancel;
  logic                take_sel;

  function automatic logic [N_SEL-1:0] lowest(
    input logic [N_SEL-1:0] v
  );
    logic [N_SEL-1:0] r;
    r = '0;
    for (int i = N_SEL - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

`ifdef VEND_MOTOR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST =
    TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt, cnt_n;
  logic          fault_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      fault <= 1'b0;
    end else begin
      cnt   <= cnt_n;
      fault <= fault_n;
    end
  end

  assign sel_ok = ~fault;
`else
  assign fault  = 1'b0;
  assign sel_ok = 1'b1;
`endif

  assign has_coin    = coin5 | coin10;
  assign take_cancel = cancel && (credit != '0);
  assign take_sel    = !take_cancel && sel_ok &&
                       (|sel) && (credit >= CPRICE);

  always_comb begin
    state_n  = state;
    credit_n = credit;
    mreq_n   = motor_req;
    msel_n   = motor_sel;
    hreq_n   = hopper_req;
    rej_n    = 1'b0;
`ifdef VEND_MOTOR_TIMEOUT_EN
    cnt_n    = cnt;
    fault_n  = fault;
`endif
    unique case (state)
      IDLE: begin
`ifdef VEND_MOTOR_TIMEOUT_EN
        cnt_n = '0;
`endif
        if (take_cancel) begin
          state_n = CHANGE;
          hreq_n  = 1'b1;
          rej_n   = has_coin;
        end else if (take_sel) begin
          state_n = VEND;
          mreq_n  = 1'b1;
          msel_n  = lowest(sel);
          rej_n   = has_coin;
        end else if (coin10) begin
          // coin5 in the same cycle always loses
          if (credit + C10 <= CMAX)
            credit_n = credit + C10;
          else
            rej_n = 1'b1;
          if (coin5)
            rej_n = 1'b1;
        end else if (coin5) begin
          if (credit + C5 <= CMAX)
            credit_n = credit + C5;
          else
            rej_n = 1'b1;
        end
      end
      VEND: begin
        rej_n = has_coin;
        if (motor_done) begin
          credit_n = credit - CPRICE;
          mreq_n   = 1'b0;
          msel_n   = '0;
          if (credit != CPRICE) begin
            state_n = CHANGE;
            hreq_n  = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
`ifdef VEND_MOTOR_TIMEOUT_EN
        else if (cnt == TLAST) begin
          // full refund: credit untouched
          mreq_n  = 1'b0;
          msel_n  = '0;
          fault_n = 1'b1;
          state_n = CHANGE;
          hreq_n  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
`endif
      end
      CHANGE: begin
        rej_n = has_coin;
        if (hopper_req && hopper_ack) begin
          credit_n = credit - C5;
          if (credit == C5) begin
            state_n = IDLE;
            hreq_n  = 1'b0;
          end
        end
      end
      default: begin
        state_n  = IDLE;
        credit_n = '0;
        mreq_n   = 1'b0;
        msel_n   = '0;
        hreq_n   = 1'b0;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      credit      <= '0;
      motor_req   <= 1'b0;
      motor_sel   <= '0;
      hopper_req  <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      credit      <= credit_n;
      motor_req   <= mreq_n;
      motor_sel   <= msel_n;
      hopper_req  <= hreq_n;
      coin_reject <= rej_n;
      busy        <= busy_n;
    end
  end

endmodule

// File: tb/tb_vend_service_controller.sv
// tb_vend_service_controller: directed bench for vend_service_controller.
// Timeout section runs only with VEND_MOTOR_TIMEOUT_EN.
module tb_vend_service_controller;

  logic       clk;
  logic       rst;
  logic       coin5;
  logic       coin10;
  logic       cancel;
  logic [3:0] sel;
  logic       motor_req;
  logic [3:0] motor_sel;
  logic       motor_done;
  logic       hopper_req;
  logic       hopper_ack;
  logic [5:0] credit;
  logic       busy;
  logic       coin_reject;
  logic       fault;

  int checks;
  int failures;

  vend_service_controller #(
    .N_SEL(4),
    .PRICE(15),
    .MAX_CREDIT(40),
    .CREDIT_W(6),
    .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .coin5(coin5),
    .coin10(coin10),
    .cancel(cancel),
    .sel(sel),
    .motor_req(motor_req),
    .motor_sel(motor_sel),
    .motor_done(motor_done),
    .hopper_req(hopper_req),
    .hopper_ack(hopper_ack),
    .credit(credit),
    .busy(busy),
    .coin_reject(coin_reject),
    .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string tag,
    input int    got,
    input int    exp
  );
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic acks(input int n);
    hopper_ack = 1'b1;
    repeat (n) cyc();
    hopper_ack = 1'b0;
  endtask

  task automatic put10();
    coin10 = 1'b1;
    cyc();
    coin10 = 1'b0;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    coin5      = 1'b0;
    coin10     = 1'b0;
    cancel     = 1'b0;
    sel        = 4'b0000;
    motor_done = 1'b0;
    hopper_ack = 1'b0;
    #3;
    chk("rst_credit", credit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mreq", motor_req, 0);
    chk("rst_hreq", hopper_req, 0);
    chk("rst_fault", fault, 0);
    cyc();
    rst = 1'b0;
    cyc();

    // exact price vend, no change
    put10();
    chk("t1_c10", credit, 10);
    coin5 = 1'b1;
    cyc();
    coin5 = 1'b0;
    chk("t1_c15", credit, 15);
    sel = 4'b0010;
    cyc();
    sel = 4'b0000;
    chk("t1_mreq", motor_req, 1);
    chk("t1_msel", motor_sel, 2);
    chk("t1_busy", busy, 1);
    cyc();
    chk("t1_hold", motor_sel, 2);
    motor_done = 1'b1;
    cyc();
    motor_done = 1'b0;
    chk("t1_cred0", credit, 0);
    chk("t1_mreq0", motor_req, 0);
    chk("t1_idle", busy, 0);
    chk("t1_hreq", hopper_req, 0);

    // two buttons, lowest wins, 5 change
    put10();
    put10();
    sel = 4'b0110;
    cyc();
    sel = 4'b0000;
    chk("t2_msel", motor_sel, 2);
    motor_done = 1'b1;
    cyc();
    motor_done = 1'b0;
    chk("t2_cred", credit, 5);
    chk("t2_hreq", hopper_req, 1);
    chk("t2_busy", busy, 1);
    acks(1);
    chk("t2_cred0", credit, 0);
    chk("t2_hreq0", hopper_req, 0);
    chk("t2_idle", busy, 0);

    // ceiling and dual coin
    repeat (4) put10();
    chk("t3_c40", credit, 40);
    coin5 = 1'b1;
    cyc();
    coin5 = 1'b0;
    chk("t3_rej", coin_reject, 1);
    chk("t3_keep", credit, 40);
    cyc();
    chk("t3_rej1", coin_reject, 0);
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
    acks(8);
    chk("t3_drain", credit, 0);
    chk("t3_idle", busy, 0);
    coin5  = 1'b1;
    coin10 = 1'b1;
    cyc();
    coin5  = 1'b0;
    coin10 = 1'b0;
    chk("t3_dual", credit, 10);
    chk("t3_drej", coin_reject, 1);

    // select below price ignored
    sel = 4'b0001;
    cyc();
    sel = 4'b0000;
    chk("t4_lowsel", motor_req, 0);
    chk("t4_lowbusy", busy, 0);
    chk("t4_lowrej", coin_reject, 0);
    hopper_ack = 1'b1;
    cyc();
    hopper_ack = 1'b0;
    chk("t4_stray", credit, 10);
    put10();
    // cancel beats select
    cancel = 1'b1;
    sel    = 4'b0001;
    cyc();
    cancel = 1'b0;
    sel    = 4'b0000;
    chk("t4_hreq", hopper_req, 1);
    chk("t4_mreq", motor_req, 0);
    coin5 = 1'b1;
    cyc();
    coin5 = 1'b0;
    chk("t4_chgrej", coin_reject, 1);
    chk("t4_chgcred", credit, 20);
    acks(4);
    chk("t4_cred0", credit, 0);
    chk("t4_idle", busy, 0);

    // async reset in CHANGE
    put10();
    coin5 = 1'b1;
    cyc();
    coin5 = 1'b0;
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
    chk("t5_chg", hopper_req, 1);
    chk("t5_c15", credit, 15);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_arst_c", credit, 0);
    chk("t5_arst_h", hopper_req, 0);
    chk("t5_arst_b", busy, 0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("t5_idle", busy, 0);
    chk("t5_cred", credit, 0);

`ifdef VEND_MOTOR_TIMEOUT_EN
    put10();
    put10();
    sel = 4'b1000;
    cyc();
    sel = 4'b0000;
    chk("t6_msel", motor_sel, 8);
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("t6_wait", motor_req, 1);
    end
    cyc();
    chk("t6_mreq0", motor_req, 0);
    chk("t6_fault", fault, 1);
    chk("t6_hreq", hopper_req, 1);
    chk("t6_refund", credit, 20);
    acks(4);
    chk("t6_cred0", credit, 0);
    put10();
    put10();
    sel = 4'b0001;
    cyc();
    sel = 4'b0000;
    chk("t6_selign", motor_req, 0);
    chk("t6_busy", busy, 0);
    chk("t6_sticky", fault, 1);
`else
    chk("t6_nofault", fault, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/vend_service_controller.md
Name: vend_service_controller

Overview:
- Top-level sequencer for a multi-product vending machine.
- Accumulates coin credit, arbitrates product-select buttons, drives a shared dispense motor through a req/done handshake, then returns change one 5-unit coin at a time through a hopper req/ack handshake.
- Sits between the coin acceptor/button front end and the motor and hopper actuator drivers.

Parameters:
- N_SEL, 4, number of product select buttons/lanes.
- PRICE, 15, price of every product in credit units; multiple of 5, ≤ MAX_CREDIT.
- MAX_CREDIT, 40, credit ceiling; multiple of 5.
- CREDIT_W, 6, credit register width; must hold MAX_CREDIT+10.
- TIMEOUT, 255, motor watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- coin5  in  1  one-cycle pulse, 5-unit coin inserted.
- coin10  in  1  one-cycle pulse, 10-unit coin inserted.
- cancel  in  1  one-cycle pulse, refund request.
- sel  in  N_SEL  product buttons, level-sampled.
- motor_req  out  1  dispense request to the motor driver.
- motor_sel  out  N_SEL  one-hot lane select; valid while motor_req=1.
- motor_done  in  1  one-cycle pulse, dispense complete.
- hopper_req  out  1  request to eject one 5-unit coin.
- hopper_ack  in  1  coin ejected; counted only when hopper_req=1.
- credit  out  CREDIT_W  current credit.
- busy  out  1  high in any state other than IDLE.
- coin_reject  out  1  one-cycle pulse, coin not accepted.
- fault  out  1  sticky watchdog fault; tied 0 without the optional feature.

Behaviour:
- Reset values: state=IDLE; credit=0; all outputs 0.
- States: IDLE, VEND, CHANGE. All outputs are registered.

IDLE, evaluated each cycle in priority order:
1. cancel=1 and credit>0: go to CHANGE.
2. Any sel bit set and credit≥PRICE: latch the lowest-index set bit into motor_sel; go to VEND. motor_req rises on the cycle after sel is sampled.
3. Coin accepted: credit += 5 or 10.

Coin rules:
- Coin inserted while state≠IDLE: rejected.
- Coin inserted in the same cycle as an accepted cancel or select: rejected.
- Coin that would push credit above MAX_CREDIT: rejected; credit unchanged.
- coin5 and coin10 in the same cycle: coin10 evaluated, coin5 rejected.
- Every rejection pulses coin_reject for exactly 1 cycle. Rejected coins are physically returned by the acceptor, not by this block.
- sel while credit<PRICE: ignored, no pulse. cancel with credit=0: ignored.

VEND:
- motor_req=1; motor_sel held stable.
- On motor_done: credit -= PRICE; motor_req and motor_sel cleared.
- Next state: CHANGE if the new credit>0, else IDLE.
- sel and cancel are ignored in VEND.

CHANGE:
- hopper_req=1.
- Each cycle with hopper_req=1 and hopper_ack=1: credit -= 5.
- When credit reaches 0: go to IDLE; hopper_req deasserts the same edge.
- hopper_ack while hopper_req=0 is ignored.
- Credit is always a multiple of 5, so it never underflows.

Other:
- busy = (state≠IDLE).
- Reset asserted mid-operation: return to IDLE immediately; credit is lost. This is intentional; the coin box records it.

Optional Feature:
- Macro: VEND_MOTOR_TIMEOUT_EN.
- Defined:
  - A counter runs while in VEND.
  - If TIMEOUT cycles elapse without motor_done: drop motor_req, set fault=1 (sticky until rst), go to CHANGE with credit unchanged (full refund).
  - While fault=1, sel is ignored; coins and cancel still work.
- Not defined: no counter; fault is constant 0; VEND waits indefinitely for motor_done.

Test Plan:
- Reset, then coin10, coin5, sel=4'b0010: credit 10→15; motor_req=1 with motor_sel=0010 the cycle after sel; motor_done → credit=0, IDLE, hopper_req never asserted.
- Coin10 ×2, sel=4'b0110: motor_sel=0010. motor_done → CHANGE, credit=5. hopper_ack → credit=0, hopper_req=0, IDLE.
- Coin10 ×4 (credit=40), then coin5: coin_reject pulse, credit stays 40. coin5 and coin10 in the same cycle at credit 0: credit=10, coin_reject=1.
- Credit=10 plus sel: ignored. cancel in the same cycle as sel with credit=20: CHANGE, 4 hopper acks, credit=0. Coin during CHANGE: rejected.
- rst asserted during CHANGE with credit=15: all outputs 0 asynchronously; IDLE after release.
- With VEND_MOTOR_TIMEOUT_EN and TIMEOUT=8, credit=20, sel, no motor_done: after 8 cycles motor_req=0, fault=1, refund 4 coins; later sel with credit≥PRICE is ignored.
